// File: rtl/banco_respondedor.sv
// banco_respondedor: bank-side responder for the card controller.
// It captures one deposit or withdrawal request on a rising edge of monto_stb,
// waits LATENCIA cycles, then answers with single-cycle result pulses and the
// updated balance. The card commission is taken from every transaction made
// with a fee-paying card.
module banco_respondedor #(
    parameter logic [31:0] BALANCE_INICIAL = 32'd50000,
    parameter logic [31:0] COMISION        = 32'd500,
    parameter int          LATENCIA        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tipo_de_tarjeta,
    input  logic        tipo_trans,
    input  logic [31:0] monto,
    input  logic        monto_stb,
    output logic        entregar_dinero,
    output logic        fondos_insuficientes,
    output logic        balance_actualizado,
    output logic [31:0] balance,
    output logic        ocupado
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ESPERA    = 2'd1;
    localparam logic [1:0] S_RESPUESTA = 2'd2;

    // The counter is loaded with LATENCIA-1 so that ESPERA lasts exactly LATENCIA edges.
    localparam logic [3:0] CNT_INI = 4'(LATENCIA - 1);

    logic [1:0]  r_estado;
    logic [3:0]  r_cnt;
    logic        r_stb_q;
    logic [31:0] r_monto;
    logic        r_tipo_trans;
    logic        r_tarjeta;
    logic [31:0] r_balance;
    logic        r_entregar;
    logic        r_fondos;
    logic        r_actualizado;
    logic        r_ocupado;

    logic        w_start;
    logic [31:0] w_cargo;
    logic [32:0] w_total;
    logic        w_aprobado;
    logic [31:0] w_saldo_dep;
    logic [31:0] w_saldo_ret;

    // Net credit of a deposit: the commission is taken out first, and never goes below zero.
    function automatic logic [31:0] f_credito(input logic [31:0] m, input logic [31:0] c);
        return (m > c) ? (m - c) : 32'd0;
    endfunction

    // Add in 33 bits and clamp to the largest representable balance.
    function automatic logic [31:0] f_suma_sat(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign w_start = monto_stb & ~r_stb_q;

    // Decision datapath, evaluated from the latched request and the current balance.
    always_comb begin
        w_cargo     = r_tarjeta ? COMISION : 32'd0;
        w_total     = {1'b0, r_monto} + {1'b0, w_cargo};
        w_aprobado  = (w_total <= {1'b0, r_balance});
        w_saldo_dep = f_suma_sat(r_balance, f_credito(r_monto, w_cargo));
        // Only used when approved, where the total fits below the balance.
        w_saldo_ret = r_balance - w_total[31:0];
    end

    // Strobe edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stb_q <= 1'b0;
        else      r_stb_q <= monto_stb;
    end

    // Request capture; these registers only hold data, so they carry no reset.
    always_ff @(posedge clk) begin
        if (r_estado == S_IDLE && w_start) begin
            r_monto      <= monto;
            r_tipo_trans <= tipo_trans;
            r_tarjeta    <= tipo_de_tarjeta;
        end
    end

    // Transaction FSM, balance register and result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado      <= S_IDLE;
            r_cnt         <= 4'd0;
            r_balance     <= BALANCE_INICIAL;
            r_entregar    <= 1'b0;
            r_fondos      <= 1'b0;
            r_actualizado <= 1'b0;
            r_ocupado     <= 1'b0;
        end else begin
            r_entregar    <= 1'b0;
            r_fondos      <= 1'b0;
            r_actualizado <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    // ocupado is still 1 here right after a reply; it drops unless a new start arrives.
                    r_ocupado <= w_start;
                    if (w_start) begin
                        r_cnt    <= CNT_INI;
                        r_estado <= S_ESPERA;
                    end
                end
                S_ESPERA: begin
                    if (r_cnt == 4'd0) r_estado <= S_RESPUESTA;
                    else               r_cnt    <= r_cnt - 4'd1;
                end
                S_RESPUESTA: begin
                    if (r_tipo_trans) begin
                        if (w_aprobado) begin
                            r_balance     <= w_saldo_ret;
                            r_entregar    <= 1'b1;
                            r_actualizado <= 1'b1;
                        end else begin
                            r_fondos      <= 1'b1;
                        end
                    end else begin
                        r_balance     <= w_saldo_dep;
                        r_actualizado <= 1'b1;
                    end
                    r_estado <= S_IDLE;
                end
                default: begin
                    r_estado  <= S_IDLE;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign entregar_dinero      = r_entregar;
    assign fondos_insuficientes = r_fondos;
    assign balance_actualizado  = r_actualizado;
    assign balance              = r_balance;
    assign ocupado              = r_ocupado;

endmodule

// File: tb/tb_banco_respondedor.sv
// Directed testbench for banco_respondedor (default parameters, LATENCIA=2).
module tb_banco_respondedor;

    logic        clk;
    logic        rst;
    logic        tipo_de_tarjeta;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic        balance_actualizado;
    logic [31:0] balance;
    logic        ocupado;

    int vectors;
    int miscompares;

    banco_respondedor dut (
        .clk                  (clk),
        .rst                  (rst),
        .tipo_de_tarjeta      (tipo_de_tarjeta),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .balance_actualizado  (balance_actualizado),
        .balance              (balance),
        .ocupado              (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        monto_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request and records what comes back over a 12-cycle window.
    // Cycle c counts edges from the capture edge (c=1); lat is c-1 of the first pulse.
    // hold: cycles monto_stb stays high; re_at: cycle after which stb is raised again for one cycle (0 = never).
    task automatic run_txn(input logic card, input logic tipo, input logic [31:0] m,
                           input int hold, input int re_at,
                           output int lat, output logic [2:0] efa, output int nrep);
        @(negedge clk);
        tipo_de_tarjeta = card;
        tipo_trans      = tipo;
        monto           = m;
        monto_stb       = 1'b1;
        lat  = -1;
        efa  = 3'b000;
        nrep = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == hold) monto_stb = 1'b0;
            if (re_at != 0 && c == re_at) monto_stb = 1'b1;
            if (re_at != 0 && c == re_at + 1) monto_stb = 1'b0;
            if (entregar_dinero || fondos_insuficientes || balance_actualizado) begin
                nrep++;
                if (lat < 0) begin
                    lat = c - 1;
                    efa = {entregar_dinero, fondos_insuficientes, balance_actualizado};
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tipo_de_tarjeta = 1'b0;
        tipo_trans = 1'b0;
        monto = 32'd0;
        monto_stb = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (balance !== 32'd50000) begin
            miscompares++;
            $display("FAIL reset_balance got %0d want 50000", balance);
        end
        vectors++;
        if ({entregar_dinero, fondos_insuficientes, balance_actualizado, ocupado} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 0000",
                     {entregar_dinero, fondos_insuficientes, balance_actualizado, ocupado});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_deposit();
        int lat; logic [2:0] efa; int nrep;
        run_txn(1'b1, 1'b0, 32'd20000, 1, 0, lat, efa, nrep);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL dep_latency got %0d want 3", lat); end
        vectors++;
        if (efa !== 3'b001) begin miscompares++; $display("FAIL dep_pulses got %b want 001", efa); end
        vectors++;
        if (nrep !== 1) begin miscompares++; $display("FAIL dep_nrep got %0d want 1", nrep); end
        vectors++;
        if (balance !== 32'd69500) begin miscompares++; $display("FAIL dep_balance got %0d want 69500", balance); end
        vectors++;
        if (ocupado !== 1'b0) begin miscompares++; $display("FAIL dep_ocupado got %b want 0", ocupado); end
    endtask

    task automatic test_withdraw_ok();
        int lat; logic [2:0] efa; int nrep;
        do_reset();
        run_txn(1'b0, 1'b1, 32'd10000, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b101 || lat !== 3) begin
            miscompares++;
            $display("FAIL wd_pulses got %b lat %0d want 101 lat 3", efa, lat);
        end
        vectors++;
        if (nrep !== 1) begin miscompares++; $display("FAIL wd_nrep got %0d want 1", nrep); end
        vectors++;
        if (balance !== 32'd40000) begin miscompares++; $display("FAIL wd_balance got %0d want 40000", balance); end
    endtask

    task automatic test_boundary();
        int lat; logic [2:0] efa; int nrep;
        do_reset();
        run_txn(1'b1, 1'b1, 32'd49500, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b101) begin miscompares++; $display("FAIL bnd_exact_pulses got %b want 101", efa); end
        vectors++;
        if (balance !== 32'd0) begin miscompares++; $display("FAIL bnd_exact_balance got %0d want 0", balance); end
        do_reset();
        run_txn(1'b1, 1'b1, 32'd49501, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b010 || nrep !== 1) begin
            miscompares++;
            $display("FAIL bnd_over_pulses got %b n=%0d want 010 n=1", efa, nrep);
        end
        vectors++;
        if (balance !== 32'd50000) begin miscompares++; $display("FAIL bnd_over_balance got %0d want 50000", balance); end
    endtask

    task automatic test_small_amounts();
        int lat; logic [2:0] efa; int nrep;
        do_reset();
        // Deposit equal to the fee: credit is zero but the balance is still confirmed.
        run_txn(1'b1, 1'b0, 32'd500, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b001 || balance !== 32'd50000) begin
            miscompares++;
            $display("FAIL fee_deposit got %b bal %0d want 001 bal 50000", efa, balance);
        end
        run_txn(1'b0, 1'b1, 32'd0, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b101 || balance !== 32'd50000) begin
            miscompares++;
            $display("FAIL zero_withdraw got %b bal %0d want 101 bal 50000", efa, balance);
        end
    endtask

    task automatic test_strobe();
        int lat; logic [2:0] efa; int nrep;
        do_reset();
        run_txn(1'b0, 1'b1, 32'd10000, 6, 0, lat, efa, nrep);
        vectors++;
        if (nrep !== 1 || balance !== 32'd40000) begin
            miscompares++;
            $display("FAIL stb_held got n=%0d bal %0d want n=1 bal 40000", nrep, balance);
        end
        run_txn(1'b0, 1'b1, 32'd10000, 1, 2, lat, efa, nrep);
        vectors++;
        if (nrep !== 1 || balance !== 32'd30000) begin
            miscompares++;
            $display("FAIL stb_busy got n=%0d bal %0d want n=1 bal 30000", nrep, balance);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] efa; int nrep;
        // Second rising edge lands on the IDLE cycle right after the reply.
        run_txn(1'b0, 1'b1, 32'd5000, 1, 4, lat, efa, nrep);
        vectors++;
        if (nrep !== 2 || balance !== 32'd20000) begin
            miscompares++;
            $display("FAIL b2b got n=%0d bal %0d want n=2 bal 20000", nrep, balance);
        end
    endtask

    task automatic test_reset_midop();
        int lat; logic [2:0] efa; int nrep; int seen;
        do_reset();
        run_txn(1'b1, 1'b0, 32'd20000, 1, 0, lat, efa, nrep);
        @(negedge clk);
        tipo_de_tarjeta = 1'b0;
        tipo_trans = 1'b1;
        monto = 32'd10000;
        monto_stb = 1'b1;
        @(posedge clk); #1;
        monto_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (ocupado !== 1'b0 || balance !== 32'd50000) begin
            miscompares++;
            $display("FAIL midop_reset got ocupado %b bal %0d want 0 bal 50000", ocupado, balance);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (entregar_dinero || fondos_insuficientes || balance_actualizado) seen++;
        end
        vectors++;
        if (seen !== 0 || balance !== 32'd50000) begin
            miscompares++;
            $display("FAIL midop_quiet got pulses %0d bal %0d want 0 bal 50000", seen, balance);
        end
        run_txn(1'b0, 1'b0, 32'd1000, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b001 || balance !== 32'd51000) begin
            miscompares++;
            $display("FAIL midop_next got %b bal %0d want 001 bal 51000", efa, balance);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [2:0] efa; int nrep;
        do_reset();
        run_txn(1'b0, 1'b0, 32'hFFFF_0000, 1, 0, lat, efa, nrep);
        vectors++;
        if (balance !== 32'hFFFF_C350) begin
            miscompares++;
            $display("FAIL sat_near got %h want ffffc350", balance);
        end
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFF, 1, 0, lat, efa, nrep);
        vectors++;
        if (efa !== 3'b001 || balance !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL sat_max got %b bal %h want 001 bal ffffffff", efa, balance);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_deposit();
        test_withdraw_ok();
        test_boundary();
        test_small_amounts();
        test_strobe();
        test_back_to_back();
        test_reset_midop();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
